// File: rtl/ac97_frame_serializer.sv
// AC97 output frame serializer: SYNC/SDATA_OUT generation, per-frame sample strobe,
// PCM slots 3/4 and a one-entry codec register-write command path in slots 1/2.
module ac97_frame_serializer (
    input  logic        I_BITCLK,
    input  logic        I_RESET,
    input  logic [19:0] I_SAMPLE_LEFT,
    input  logic [19:0] I_SAMPLE_RIGHT,
    input  logic        I_PCM_EN,
    input  logic        I_CMD_VALID,
    input  logic [6:0]  I_CMD_ADDR,
    input  logic [15:0] I_CMD_DATA,
    output logic        O_CMD_READY,
    output logic        O_STROBE,
    output logic        O_SYNC,
    output logic        O_SDATA_OUT
);

    localparam int unsigned FRAME_BITS = 256;
    localparam int unsigned CNT_W      = 8;
    localparam int unsigned SYNC_BITS  = 16;
    localparam int unsigned TAG_W      = 16;
    localparam int unsigned SLOT_W     = 20;
    localparam int unsigned ADDR_W     = 7;
    localparam int unsigned DATA_W     = 16;
    localparam int unsigned SHIFT_W    = TAG_W + 4 * SLOT_W;

    logic [CNT_W-1:0]   bit_cnt;
    logic               running;
    logic [SHIFT_W-1:0] shift_reg;
    logic               cmd_full;
    logic [ADDR_W-1:0]  cmd_addr;
    logic [DATA_W-1:0]  cmd_data;

    logic               frame_load;
    logic               cmd_accept;
    logic               full_next;
    logic [CNT_W-1:0]   bit_next;
    logic [TAG_W-1:0]   tag;
    logic [SLOT_W-1:0]  slot1;
    logic [SLOT_W-1:0]  slot2;
    logic [SLOT_W-1:0]  slot3;
    logic [SLOT_W-1:0]  slot4;
    logic [SHIFT_W-1:0] frame_new;

    // Frame assembly from live inputs; only consumed on the frame-load edge.
    always_comb begin
        frame_load = !running || (bit_cnt == CNT_W'(FRAME_BITS - 1));
        cmd_accept = I_CMD_VALID & O_CMD_READY;
        bit_next   = frame_load ? '0 : bit_cnt + CNT_W'(1);
        full_next  = frame_load ? cmd_accept : (cmd_full | cmd_accept);
        tag        = {1'b1, {2{cmd_full}}, {2{I_PCM_EN}}, 11'b0};
        slot1      = cmd_full ? {1'b0, cmd_addr, 12'b0} : '0;
        slot2      = cmd_full ? {cmd_data, 4'b0} : '0;
        slot3      = I_PCM_EN ? I_SAMPLE_LEFT : '0;
        slot4      = I_PCM_EN ? I_SAMPLE_RIGHT : '0;
        frame_new  = {tag, slot1, slot2, slot3, slot4};
    end

    // Bits 96..255 are always zero, so a 96-bit shift register filled with zeros covers the frame.
    always_ff @(posedge I_BITCLK) begin
        if (I_RESET) begin
            bit_cnt     <= '0;
            running     <= 1'b0;
            shift_reg   <= '0;
            cmd_full    <= 1'b0;
            cmd_addr    <= '0;
            cmd_data    <= '0;
            O_CMD_READY <= 1'b0;
            O_STROBE    <= 1'b0;
            O_SYNC      <= 1'b0;
            O_SDATA_OUT <= 1'b0;
        end else begin
            running  <= 1'b1;
            bit_cnt  <= bit_next;
            O_SYNC   <= (bit_next < CNT_W'(SYNC_BITS));
            O_STROBE <= frame_load;
            if (frame_load) begin
                shift_reg   <= {frame_new[SHIFT_W-2:0], 1'b0};
                O_SDATA_OUT <= frame_new[SHIFT_W-1];
            end else begin
                shift_reg   <= {shift_reg[SHIFT_W-2:0], 1'b0};
                O_SDATA_OUT <= shift_reg[SHIFT_W-1];
            end
            cmd_full    <= full_next;
            O_CMD_READY <= !full_next;
            if (cmd_accept) begin
                cmd_addr <= I_CMD_ADDR;
                cmd_data <= I_CMD_DATA;
            end
        end
    end

endmodule

// File: tb/tb_ac97_frame_serializer.sv
// Scoreboard bench for ac97_frame_serializer: frame-level reference model plus
// directed frame-content checks on captured serial frames.
module tb_ac97_frame_serializer;

    logic        clk = 1'b0;
    logic        rst;
    logic [19:0] left, right;
    logic        pen, valid;
    logic [6:0]  addr;
    logic [15:0] data;
    logic        ready, strobe, sync, sdata;

    always #5 clk = ~clk;

    ac97_frame_serializer dut (
        .I_BITCLK      (clk),
        .I_RESET       (rst),
        .I_SAMPLE_LEFT (left),
        .I_SAMPLE_RIGHT(right),
        .I_PCM_EN      (pen),
        .I_CMD_VALID   (valid),
        .I_CMD_ADDR    (addr),
        .I_CMD_DATA    (data),
        .O_CMD_READY   (ready),
        .O_STROBE      (strobe),
        .O_SYNC        (sync),
        .O_SDATA_OUT   (sdata)
    );

    typedef struct packed {
        logic sync;
        logic strobe;
        logic sdata;
        logic ready;
    } exp_t;

    typedef struct packed {
        logic [6:0]  a;
        logic [15:0] d;
    } cmd_t;

    int checks = 0;
    int errors = 0;

    // Reference model state
    exp_t exp_q[$];
    bit   started = 0;
    int   mb = 0;
    bit   mframe[256];
    cmd_t mbuf[$];
    bit   m_ready = 0;
    int   acc_cnt = 0;

    function automatic void put(int off, int w, logic [31:0] v);
        for (int i = 0; i < w; i++) mframe[off + i] = v[w - 1 - i];
    endfunction

    function automatic void build_frame();
        bit   cp;
        cmd_t c;
        cp = (mbuf.size() > 0);
        c  = '0;
        if (cp) c = mbuf.pop_front();
        for (int i = 0; i < 256; i++) mframe[i] = 0;
        put(0, 16, 32'h8000 + (cp ? 32'h6000 : 32'h0) + (pen ? 32'h1800 : 32'h0));
        if (cp) begin
            put(16, 20, 32'(int'(c.a) * 4096));
            put(36, 20, 32'(int'(c.d) * 16));
        end
        if (pen) begin
            put(56, 20, 32'(left));
            put(76, 20, 32'(right));
        end
    endfunction

    function automatic void model_edge();
        exp_t e;
        bit   acc;
        e = '0;
        if (rst) begin
            started = 0;
            mb      = 0;
            mbuf.delete();
            m_ready = 0;
        end else begin
            acc = valid && m_ready;
            if (!started || mb == 255) begin
                build_frame();
                mb      = 0;
                started = 1;
            end else begin
                mb++;
            end
            if (acc) begin
                mbuf.push_back('{a: addr, d: data});
                acc_cnt++;
            end
            m_ready  = (mbuf.size() == 0);
            e.sync   = (mb < 16);
            e.strobe = (mb == 0);
            e.sdata  = mframe[mb];
            e.ready  = m_ready;
        end
        exp_q.push_back(e);
    endfunction

    // Monitor: per-cycle scoreboard compare and serial frame capture
    int          cap_idx = 96;
    logic [95:0] cap_vec;
    logic [95:0] frames[$];

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({sync, strobe, sdata, ready} !== e) begin
                errors++;
                $display("FAIL outputs t=%0t b=%0d got sync/strobe/sdata/ready=%b required=%b",
                         $time, mb, {sync, strobe, sdata, ready}, e);
            end
        end
        if (strobe === 1'b1) cap_idx = 0;
        if (cap_idx < 96) begin
            cap_vec[95 - cap_idx] = sdata;
            cap_idx++;
            if (cap_idx == 96) frames.push_back(cap_vec);
        end
    end

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic run_to(int target);
        int n = 0;
        while (!(started && mb == target) && n < 1000) begin
            tick();
            n++;
        end
        if (n >= 1000) begin
            checks++;
            errors++;
            $display("FAIL run_to timeout got b=%0d required b=%0d", mb, target);
        end
    endtask

    task automatic next_frame_capture();
        frames.delete();
        run_to(255);
        tick();
        run_to(100);
    endtask

    task automatic check_frame(string name, logic [95:0] expv);
        logic [95:0] got;
        checks++;
        if (frames.size() == 0) begin
            errors++;
            $display("FAIL %s no frame captured, required %h", name, expv);
        end else begin
            got = frames[$];
            if (got !== expv) begin
                errors++;
                $display("FAIL %s got %h required %h", name, got, expv);
            end
        end
        frames.delete();
    endtask

    task automatic wait_acc(int target);
        int n = 0;
        while (acc_cnt < target && n < 600) begin
            tick();
            n++;
        end
        if (acc_cnt < target) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout got %0d accepts required %0d", acc_cnt, target);
        end
    endtask

    initial begin
        rst = 1; left = '0; right = '0; pen = 0; valid = 0; addr = '0; data = '0;
        repeat (4) tick();

        // First frame after release: PCM on, no command
        left = 20'h12345; right = 20'hFEDCB; pen = 1; rst = 0;
        frames.delete();
        run_to(100);
        check_frame("pcm_on", {16'h9800, 20'h0, 20'h0, 20'h12345, 20'hFEDCB});

        pen = 0;
        next_frame_capture();
        check_frame("pcm_off", {16'h8000, 20'h0, 20'h0, 20'h0, 20'h0});

        // Single command accepted mid-frame
        pen = 1;
        run_to(99);
        valid = 1; addr = 7'h02; data = 16'h0808;
        tick();
        valid = 0;
        next_frame_capture();
        check_frame("cmd_frame", {16'hF800, 20'h02000, 20'h08080, 20'h12345, 20'hFEDCB});
        next_frame_capture();
        check_frame("after_cmd", {16'h9800, 20'h0, 20'h0, 20'h12345, 20'hFEDCB});

        // Back-to-back commands with valid held
        run_to(10);
        valid = 1; addr = 7'h11; data = 16'hAAAA;
        wait_acc(acc_cnt + 1);
        addr = 7'h22; data = 16'h5555;
        wait_acc(acc_cnt + 1);
        valid = 0;
        frames.delete();
        run_to(100);
        check_frame("b2b_first", {16'hF800, 20'h11000, 20'hAAAA0, 20'h12345, 20'hFEDCB});
        next_frame_capture();
        check_frame("b2b_second", {16'hF800, 20'h22000, 20'h55550, 20'h12345, 20'hFEDCB});

        // Reset mid-frame drops the buffered command
        run_to(20);
        valid = 1; addr = 7'h33; data = 16'h1234;
        tick();
        valid = 0;
        run_to(60);
        frames.delete();
        rst = 1;
        tick();
        tick();
        rst = 0;
        run_to(100);
        check_frame("reset_drop", {16'h9800, 20'h0, 20'h0, 20'h12345, 20'hFEDCB});

        // Randomized traffic against the reference model
        for (int i = 0; i < 4000; i++) begin
            left  = 20'($urandom);
            right = 20'($urandom);
            if ($urandom_range(0, 7) == 0) pen = ~pen;
            valid = ($urandom_range(0, 3) == 0);
            addr  = 7'($urandom);
            data  = 16'($urandom);
            rst   = ($urandom_range(0, 699) == 0);
            tick();
        end
        rst = 0; valid = 0;
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
